digit_frame_ctrl: RTL

//  Sequences the digit/text display datapath. Accepts digit requests over a valid/ready handshake,

---
 rtl/vga_pkg.sv | 26 ++
 rtl/txt_lfsr5.sv | 44 ++++
 rtl/digit_frame_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the digit/text display datapath.
// Contents:
//   disp_state_t  - display controller state encoding
//   INSTR_SEL     - caption index of the instruction screen
//   DIGIT_MAX     - largest legal digit value
//   OPTIONS_DEF   - default number of caption strings
//   LFSR_SEED_DEF - default (non-zero) caption LFSR seed
//   lfsr5_next    - one step of the 5-bit caption LFSR
package vga_pkg;

    typedef enum logic [1:0] {
        S_INSTR,
        S_PEND,
        S_SHOW
    } disp_state_t;

    localparam logic [3:0]  INSTR_SEL     = 4'd0;
    localparam logic [3:0]  DIGIT_MAX     = 4'd9;
    localparam int unsigned OPTIONS_DEF   = 10;
    localparam logic [4:0]  LFSR_SEED_DEF = 5'b00011;

    function automatic logic [4:0] lfsr5_next(input logic [4:0] q);
        return {q[3:0], q[4] ^ q[2]};
    endfunction

endpackage

// File: rtl/txt_lfsr5.sv
// Pseudo-random caption selector: a 5-bit LFSR stepped on request, with its
// low nibble folded onto the legal caption range 1..OPTIONS-1.
// Ports:
//   pixClk_i - clock
//   reset_i  - asynchronous active-low reset (LFSR returns to LFSR_SEED)
//   step_i   - advance the LFSR by one step on this edge
//   sel_o    - mapped caption index of the current LFSR value (never 0)
module txt_lfsr5
    import vga_pkg::*;
#(
    parameter int unsigned OPTIONS   = OPTIONS_DEF,
    parameter logic [4:0]  LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic       pixClk_i,
    input  logic       reset_i,
    input  logic       step_i,
    output logic [3:0] sel_o
);

    logic [4:0] lfsr_q, lfsr_d;
    logic [3:0] s;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = lfsr5_next(lfsr_q);
        end
    end

    always_ff @(posedge pixClk_i or negedge reset_i) begin
        if (!reset_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Index 0 is the instruction screen, so out-of-range values fold to caption 1.
    always_comb begin
        s     = lfsr_q[3:0];
        sel_o = ((s >= 4'd1) && ({28'd0, s} < OPTIONS)) ? s : 4'd1;
    end

endmodule

// File: rtl/digit_frame_ctrl.sv
// Display sequencer: accepts digit requests over valid/ready, holds them until
// the next frame boundary (derived from vSync) and then updates digit, digitEn
// and txtSelect together so the picture never tears. Reverts to the
// instruction screen after TIMEOUT_FRAMES idle frames.
// Ports:
//   pixClk_i     - pixel clock, the only clock
//   reset_i      - asynchronous active-low reset
//   vSync_i      - active-low vertical sync
//   reqValid_i   - requester has a digit
//   reqDigit_i   - requested digit (legal 0..9)
//   reqReady_o   - controller can accept a request
//   digit_o      - digit to display
//   digitEn_o    - 1 = draw digit, 0 = instruction screen
//   txtSelect_o  - caption index
//   frameTick_o  - one-cycle frame boundary pulse
//   errPulse_o   - one-cycle pulse when an illegal digit is accepted
module digit_frame_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned OPTIONS        = OPTIONS_DEF,
    parameter int unsigned TIMEOUT_FRAMES = 600,
    parameter int unsigned CNT_W          = 16,
    parameter logic [4:0]  LFSR_SEED      = LFSR_SEED_DEF
) (
    input  logic       pixClk_i,
    input  logic       reset_i,
    input  logic       vSync_i,
    input  logic       reqValid_i,
    input  logic [3:0] reqDigit_i,
    output logic       reqReady_o,
    output logic [3:0] digit_o,
    output logic       digitEn_o,
    output logic [3:0] txtSelect_o,
    output logic       frameTick_o,
    output logic       errPulse_o
);

    // Saturation ceiling of the frame counter; with no timeout it just runs to all-ones.
    localparam logic [CNT_W-1:0] CntMax = (TIMEOUT_FRAMES == 0) ? {CNT_W{1'b1}}
                                                                : CNT_W'(TIMEOUT_FRAMES - 1);

    disp_state_t      state_q, state_d;
    logic             vs1_q, vs2_q;
    logic [3:0]       digit_q, digit_d;
    logic [3:0]       pend_q, pend_d;
    logic             digit_en_q, digit_en_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             from_instr_q, from_instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick, xfer, legal, lfsr_step;
    logic [3:0]       lfsr_sel;

    assign tick  = vs2_q & ~vs1_q;
    assign xfer  = reqValid_i & ready_q;
    assign legal = (reqDigit_i <= DIGIT_MAX);

    txt_lfsr5 #(
        .OPTIONS   (OPTIONS),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .pixClk_i (pixClk_i),
        .reset_i  (reset_i),
        .step_i   (lfsr_step),
        .sel_o    (lfsr_sel)
    );

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        pend_d       = pend_q;
        digit_en_d   = digit_en_q;
        from_instr_d = from_instr_q;
        cnt_d        = cnt_q;
        lfsr_step    = 1'b0;
        err_d        = xfer & ~legal;

        unique case (state_q)
            S_INSTR: begin
                if (xfer && legal) begin
                    pend_d       = reqDigit_i;
                    from_instr_d = 1'b1;
                    state_d      = S_PEND;
                end
            end
            S_PEND: begin
                if (tick) begin
                    digit_d    = pend_q;
                    digit_en_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_SHOW;
                    // A repeat of the shown digit keeps its caption.
                    lfsr_step  = from_instr_q || (pend_q != digit_q);
                end
            end
            S_SHOW: begin
                if (xfer && legal) begin
                    // Timeout is suppressed once a new digit is pending.
                    pend_d       = reqDigit_i;
                    from_instr_d = 1'b0;
                    state_d      = S_PEND;
                    if (tick && (cnt_q != CntMax)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (tick) begin
                    if ((TIMEOUT_FRAMES != 0) && (cnt_q == CntMax)) begin
                        digit_en_d = 1'b0;
                        state_d    = S_INSTR;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_INSTR;
        endcase

        ready_d = (state_d != S_PEND);
    end

    always_ff @(posedge pixClk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= S_INSTR;
            vs1_q        <= 1'b1;
            vs2_q        <= 1'b1;
            digit_q      <= '0;
            pend_q       <= '0;
            digit_en_q   <= 1'b0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            from_instr_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            vs1_q        <= vSync_i;
            vs2_q        <= vs1_q;
            digit_q      <= digit_d;
            pend_q       <= pend_d;
            digit_en_q   <= digit_en_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            from_instr_q <= from_instr_d;
            cnt_q        <= cnt_d;
        end
    end

    // The LFSR only moves on commits that need a new caption, so its mapped
    // value is the caption whenever a digit is drawn.
    assign txtSelect_o = digit_en_q ? lfsr_sel : INSTR_SEL;
    assign reqReady_o  = ready_q;
    assign digit_o     = digit_q;
    assign digitEn_o   = digit_en_q;
    assign frameTick_o = tick;
    assign errPulse_o  = err_q;

endmodule
